// File: rtl/peripheral_bridge_ahb2apb4_if.sv
//============================================================================
// Module      : peripheral_bridge_ahb2apb4_if
// Description : AHB-Lite slave side and APB4 master side of the bridge.
// Revision    : 1.0
//============================================================================
`default_nettype none

interface peripheral_bridge_ahb2apb4_if #(
    parameter int HADDR_SIZE = 16,
    parameter int HDATA_SIZE = 32
);
    logic                      HSEL;
    logic [HADDR_SIZE-1:0]     HADDR;
    logic [HDATA_SIZE-1:0]     HWDATA;
    logic [HDATA_SIZE-1:0]     HRDATA;
    logic                      HWRITE;
    logic [2:0]                HSIZE;
    logic [2:0]                HBURST;
    logic [3:0]                HPROT;
    logic [1:0]                HTRANS;
    logic                      HMASTLOCK;
    logic                      HREADY;
    logic                      HREADYOUT;
    logic                      HRESP;

    logic                      PSEL;
    logic                      PENABLE;
    logic [HADDR_SIZE-1:0]     PADDR;
    logic                      PWRITE;
    logic [HDATA_SIZE-1:0]     PWDATA;
    logic [HDATA_SIZE/8-1:0]   PSTRB;
    logic [2:0]                PPROT;
    logic [HDATA_SIZE-1:0]     PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
               HMASTLOCK, HREADY,
        output HRDATA, HREADYOUT, HRESP,
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
               HMASTLOCK, HREADY,
        input  HRDATA, HREADYOUT, HRESP,
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

`default_nettype wire

// File: rtl/peripheral_bridge_ahb2apb4.sv
//============================================================================
// Module      : peripheral_bridge_ahb2apb4
// Description : AHB-Lite slave to APB4 master bridge, one APB transfer per beat.
// Revision    : 1.0
//============================================================================
`default_nettype none

module peripheral_bridge_ahb2apb4 #(
    parameter int HADDR_SIZE = 16,
    parameter int HDATA_SIZE = 32
) (
    input  wire logic                    HCLK,
    input  wire logic                    HRESETn,
    peripheral_bridge_ahb2apb4_if.slave  bus
);

    localparam int         NB       = HDATA_SIZE / 8;
    localparam int         OFFW     = $clog2(NB);
    localparam logic [2:0] MAX_SIZE = 3'(OFFW);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WDATA  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_ERR1   = 3'd4,
        S_ERR2   = 3'd5
    } state_t;

    state_t                  state_q;
    logic                    psel_q;
    logic                    penable_q;
    logic [HADDR_SIZE-1:0]   paddr_q;
    logic                    pwrite_q;
    logic [HDATA_SIZE-1:0]   pwdata_q;
    logic [NB-1:0]           pstrb_q;
    logic [2:0]              pprot_q;
    logic                    hreadyout_q;
    logic                    hresp_q;
    logic [HDATA_SIZE-1:0]   hrdata_q;

    logic                    w_accept;
    logic                    w_size_err;
    logic [OFFW-1:0]         w_off;
    logic [NB-1:0]           w_strb;
    logic [2:0]              w_prot;
    logic                    w_unused;

    assign w_accept   = bus.HSEL & bus.HREADY & bus.HTRANS[1] &
                        ((state_q == S_IDLE) | (state_q == S_ERR2));
    assign w_size_err = (bus.HSIZE > MAX_SIZE);
    assign w_off      = bus.HADDR[OFFW-1:0];
    assign w_prot     = {~bus.HPROT[0], 1'b1, bus.HPROT[1]};
    assign w_unused   = ^{bus.HBURST, bus.HMASTLOCK, bus.HTRANS[0], bus.HPROT[3:2]};

    // Strobes are aligned down to the natural boundary of the access size.
    always_comb begin
        w_strb = '0;
        if (bus.HWRITE) begin
            case (bus.HSIZE)
                3'd0:    w_strb = NB'(1)  << w_off;
                3'd1:    w_strb = NB'(3)  << {w_off[OFFW-1:1], 1'b0};
                3'd2:    w_strb = NB'(15) << (w_off & ~OFFW'(3));
                default: w_strb = '1;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_ERR2: begin
                    state_q     <= S_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b0;
                    if (w_accept) begin
                        paddr_q     <= bus.HADDR;
                        pwrite_q    <= bus.HWRITE;
                        pstrb_q     <= w_strb;
                        pprot_q     <= w_prot;
                        hreadyout_q <= 1'b0;
                        if (w_size_err) begin
                            state_q <= S_ERR1;
                            hresp_q <= 1'b1;
                        end else if (bus.HWRITE) begin
                            state_q <= S_WDATA;
                        end else begin
                            state_q <= S_SETUP;
                            psel_q  <= 1'b1;
                        end
                    end
                end
                S_WDATA: begin
                    pwdata_q <= bus.HWDATA;
                    psel_q   <= 1'b1;
                    state_q  <= S_SETUP;
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (bus.PREADY) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        if (bus.PSLVERR) begin
                            state_q <= S_ERR1;
                            hresp_q <= 1'b1;
                        end else begin
                            if (!pwrite_q) begin
                                hrdata_q <= bus.PRDATA;
                            end
                            hreadyout_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end
                    end
                end
                S_ERR1: begin
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b1;
                    state_q     <= S_ERR2;
                end
                default: begin
                    state_q     <= S_IDLE;
                    psel_q      <= 1'b0;
                    penable_q   <= 1'b0;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PSTRB     = pstrb_q;
    assign bus.PPROT     = pprot_q;
    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
    assign bus.HRDATA    = hrdata_q;

endmodule

`default_nettype wire

// File: tb/tb_peripheral_bridge_ahb2apb4.sv
//============================================================================
// Module      : tb_peripheral_bridge_ahb2apb4
// Description : Directed self-checking bench for the AHB-Lite to APB4 bridge.
// Revision    : 1.0
//============================================================================
`default_nettype none

module tb_peripheral_bridge_ahb2apb4;

    localparam int AW = 16;
    localparam int DW = 32;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;

    always #5 HCLK = ~HCLK;

    peripheral_bridge_ahb2apb4_if #(.HADDR_SIZE(AW), .HDATA_SIZE(DW)) bus ();

    peripheral_bridge_ahb2apb4 #(.HADDR_SIZE(AW), .HDATA_SIZE(DW)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    // Single-slave system: bus ready is the bridge's own ready.
    logic        use_fix;
    logic [31:0] fix_val;
    assign bus.HREADY = bus.HREADYOUT;
    assign bus.PRDATA = use_fix ? fix_val : {16'hC0DE, bus.PADDR};

    int          n_cmp = 0;
    int          n_err = 0;
    logic [3:0]  strb_seen;
    logic        err1_seen;
    logic [31:0] rdata;
    int          waits;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic ahb_idle();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'd0;
    endtask

    // One AHB beat; returns in the HREADYOUT=1 cycle with the wait-state count.
    task automatic xfer(input logic [15:0] addr, input logic wr, input logic [2:0] sz,
                        input logic [1:0] tr, input logic [31:0] wd, input int stall,
                        input logic serr, output int nwait);
        int acc;
        acc          = 0;
        bus.HSEL     = 1'b1;
        bus.HADDR    = addr;
        bus.HWRITE   = wr;
        bus.HSIZE    = sz;
        bus.HTRANS   = tr;
        tick();
        ahb_idle();
        bus.HWDATA   = wd;
        nwait        = 0;
        strb_seen    = 4'h0;
        err1_seen    = 1'b0;
        while (!bus.HREADYOUT && nwait < 50) begin
            if (bus.PSEL && !bus.PENABLE) strb_seen = bus.PSTRB;
            if (bus.HRESP) err1_seen = 1'b1;
            if (bus.PSEL && bus.PENABLE) begin
                bus.PREADY  = (acc >= stall);
                bus.PSLVERR = serr && bus.PREADY;
                acc++;
            end else begin
                bus.PREADY  = 1'b1;
                bus.PSLVERR = 1'b0;
            end
            nwait++;
            tick();
            if (nwait == 1) bus.HWDATA = 32'hBAD0_BAD0;
        end
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b0;
        rdata       = bus.HRDATA;
        check("xfer_timeout", 64'(nwait >= 50), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        bus.HSEL = 1'b0;  bus.HADDR = '0;  bus.HWDATA = '0;  bus.HWRITE = 1'b0;
        bus.HSIZE = 3'd0; bus.HBURST = 3'd0; bus.HPROT = 4'b0011; bus.HTRANS = 2'd0;
        bus.HMASTLOCK = 1'b0; bus.PREADY = 1'b1; bus.PSLVERR = 1'b0;
        use_fix = 1'b0; fix_val = '0;

        repeat (3) tick();
        check("rst_hreadyout", 64'(bus.HREADYOUT), 64'd1);
        check("rst_hresp",     64'(bus.HRESP),     64'd0);
        check("rst_psel",      64'(bus.PSEL),      64'd0);
        check("rst_penable",   64'(bus.PENABLE),   64'd0);
        check("rst_paddr",     64'(bus.PADDR),     64'd0);
        check("rst_pwdata",    64'(bus.PWDATA),    64'd0);
        check("rst_pstrb",     64'(bus.PSTRB),     64'd0);
        check("rst_pprot",     64'(bus.PPROT),     64'd0);
        check("rst_hrdata",    64'(bus.HRDATA),    64'd0);
        HRESETn = 1'b1;
        tick();

        // Single word write, cycle by cycle
        bus.HSEL = 1'b1; bus.HADDR = 16'h0040; bus.HWRITE = 1'b1;
        bus.HSIZE = 3'd2; bus.HTRANS = 2'd2;
        tick();
        ahb_idle();
        bus.HWDATA = 32'hDEAD_BEEF;
        check("w_a1_hready", 64'(bus.HREADYOUT), 64'd0);
        check("w_a1_psel",   64'(bus.PSEL),      64'd0);
        tick();
        bus.HWDATA = 32'h0;
        check("w_a2_psel",   64'(bus.PSEL),      64'd1);
        check("w_a2_penable",64'(bus.PENABLE),   64'd0);
        check("w_a2_paddr",  64'(bus.PADDR),     64'h40);
        check("w_a2_pwdata", 64'(bus.PWDATA),    64'hDEAD_BEEF);
        check("w_a2_pstrb",  64'(bus.PSTRB),     64'hF);
        check("w_a2_pwrite", 64'(bus.PWRITE),    64'd1);
        check("w_a2_pprot",  64'(bus.PPROT),     64'h3);
        check("w_a2_hready", 64'(bus.HREADYOUT), 64'd0);
        tick();
        check("w_a3_psel",   64'(bus.PSEL),      64'd1);
        check("w_a3_penable",64'(bus.PENABLE),   64'd1);
        check("w_a3_hready", 64'(bus.HREADYOUT), 64'd0);
        tick();
        check("w_a4_hready", 64'(bus.HREADYOUT), 64'd1);
        check("w_a4_psel",   64'(bus.PSEL),      64'd0);
        check("w_a4_penable",64'(bus.PENABLE),   64'd0);
        check("w_a4_hresp",  64'(bus.HRESP),     64'd0);
        check("w_hrdata_hold", 64'(bus.HRDATA),  64'd0);

        // Read with two stall cycles
        use_fix = 1'b1; fix_val = 32'h1234_5678;
        xfer(16'h0010, 1'b0, 3'd2, 2'd2, 32'h0, 2, 1'b0, waits);
        check("rd_stall_waits", 64'(waits),     64'd4);
        check("rd_stall_data",  64'(rdata),     64'h1234_5678);
        check("rd_stall_pstrb", 64'(strb_seen), 64'h0);
        check("rd_stall_hresp", 64'(bus.HRESP), 64'd0);
        use_fix = 1'b0;

        // Byte / halfword / word strobes
        xfer(16'h0003, 1'b1, 3'd0, 2'd2, 32'h0000_0011, 0, 1'b0, waits);
        check("wb3_pstrb", 64'(strb_seen), 64'h8);
        check("wb3_waits", 64'(waits),     64'd3);
        xfer(16'h0002, 1'b1, 3'd1, 2'd2, 32'h0000_2222, 0, 1'b0, waits);
        check("wh2_pstrb", 64'(strb_seen), 64'hC);
        xfer(16'h0001, 1'b1, 3'd0, 2'd2, 32'h0000_3333, 0, 1'b0, waits);
        check("wb1_pstrb", 64'(strb_seen), 64'h2);
        xfer(16'h0006, 1'b1, 3'd2, 2'd2, 32'hA1B2_C3D4, 0, 1'b0, waits);
        check("ww6_pstrb",  64'(strb_seen),  64'hF);
        check("ww6_pwdata", 64'(bus.PWDATA), 64'hA1B2_C3D4);
        check("ww6_paddr",  64'(bus.PADDR),  64'h6);
        check("rd_hold_after_writes", 64'(bus.HRDATA), 64'h1234_5678);

        // Slave error on a write
        xfer(16'h0044, 1'b1, 3'd2, 2'd2, 32'h5555_AAAA, 0, 1'b1, waits);
        check("serr_waits",  64'(waits),         64'd4);
        check("serr_err1",   64'(err1_seen),     64'd1);
        check("serr_hresp2", 64'(bus.HRESP),     64'd1);
        check("serr_hready2",64'(bus.HREADYOUT), 64'd1);
        tick();
        check("serr_idle_hresp",  64'(bus.HRESP),     64'd0);
        check("serr_idle_hready", 64'(bus.HREADYOUT), 64'd1);
        check("serr_idle_psel",   64'(bus.PSEL),      64'd0);

        // Illegal size, then a read accepted straight from ERR2
        xfer(16'h0048, 1'b1, 3'd3, 2'd2, 32'h0, 0, 1'b0, waits);
        check("size_waits", 64'(waits),     64'd1);
        check("size_err1",  64'(err1_seen), 64'd1);
        check("size_hresp", 64'(bus.HRESP), 64'd1);
        check("size_noapb", 64'(strb_seen), 64'h0);
        xfer(16'h0030, 1'b0, 3'd2, 2'd2, 32'h0, 0, 1'b0, waits);
        check("err2_rd_waits", 64'(waits),     64'd2);
        check("err2_rd_data",  64'(rdata),     64'hC0DE_0030);
        check("err2_rd_hresp", 64'(bus.HRESP), 64'd0);

        // INCR4 read with a BUSY before the third beat
        bus.HBURST = 3'b011;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                bus.HSEL = 1'b1; bus.HTRANS = 2'd1; bus.HADDR = 16'h0028;
                tick();
                check("busy_hready", 64'(bus.HREADYOUT), 64'd1);
                check("busy_hresp",  64'(bus.HRESP),     64'd0);
                check("busy_psel",   64'(bus.PSEL),      64'd0);
            end
            xfer(16'(16'h0020 + 4 * i), 1'b0, 3'd2, (i == 0) ? 2'd2 : 2'd3, 32'h0, 0, 1'b0, waits);
            check("incr4_data",  64'(rdata),    64'(32'hC0DE_0020 + 4 * i));
            check("incr4_waits", 64'(waits),    64'd2);
            check("incr4_psel",  64'(bus.PSEL), 64'd0);
        end
        bus.HBURST = 3'd0;

        // Reset while in ACCESS
        bus.HSEL = 1'b1; bus.HADDR = 16'h0050; bus.HWRITE = 1'b1;
        bus.HSIZE = 3'd2; bus.HTRANS = 2'd2;
        tick();
        ahb_idle();
        bus.HWDATA = 32'h0BAD_F00D;
        tick();
        tick();
        bus.PREADY = 1'b0;
        check("rst_acc_penable", 64'(bus.PENABLE), 64'd1);
        #2;
        HRESETn = 1'b0;
        #1;
        check("rst_acc_psel",    64'(bus.PSEL),      64'd0);
        check("rst_acc_penable0",64'(bus.PENABLE),   64'd0);
        check("rst_acc_hready",  64'(bus.HREADYOUT), 64'd1);
        check("rst_acc_paddr",   64'(bus.PADDR),     64'd0);
        tick();
        tick();
        HRESETn = 1'b1;
        bus.PREADY = 1'b1;
        tick();
        xfer(16'h0054, 1'b1, 3'd2, 2'd2, 32'hCAFE_F00D, 0, 1'b0, waits);
        check("post_rst_waits",  64'(waits),      64'd3);
        check("post_rst_pwdata", 64'(bus.PWDATA), 64'hCAFE_F00D);
        check("post_rst_paddr",  64'(bus.PADDR),  64'h54);
        check("post_rst_hresp",  64'(bus.HRESP),  64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
